// File: rtl/bp_pht_ctrl_if.sv
// Handshake bundle between fetch, execute and the PHT for bp_pht_ctrl.
// The controller takes the slave view; the fetch/execute/PHT environment takes the master view.
interface bp_pht_ctrl_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned w_ind = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             lk_valid;
  logic [W-1:0]     lk_pc;
  logic             lk_ready;
  logic             pred_out_valid;
  logic             pred_out_taken;
  logic             res_valid;
  logic             res_taken;
  logic             res_ready;
  logic             mispredict;
  logic             pht_predict;
  logic             pht_resolve;
  logic             pht_incr;
  logic             pht_decr;
  logic [w_ind-1:0] pht_index;
  logic             pht_pred;
  logic             pht_pred_valid;
  logic [CW-1:0]    fifo_cnt;

  modport master (
    output lk_valid, lk_pc, res_valid, res_taken, pht_pred, pht_pred_valid,
    input  lk_ready, pred_out_valid, pred_out_taken, res_ready, mispredict,
           pht_predict, pht_resolve, pht_incr, pht_decr, pht_index, fifo_cnt
  );

  modport slave (
    input  lk_valid, lk_pc, res_valid, res_taken, pht_pred, pht_pred_valid,
    output lk_ready, pred_out_valid, pred_out_taken, res_ready, mispredict,
           pht_predict, pht_resolve, pht_incr, pht_decr, pht_index, fifo_cnt
  );
endinterface

// File: rtl/bp_pht_ctrl.sv
// Branch-prediction PHT controller: lookup/resolve sequencing with an in-order in-flight FIFO.
// Optional macro BP_GHR_XOR_EN selects gshare indexing (PC XOR global history); default is bimodal.
module bp_pht_ctrl #(
  parameter int unsigned W     = 32,
  parameter int unsigned w_ind = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  bp_pht_ctrl_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = 3;
  localparam logic [TW-1:0] TMO_LAST = TW'(7);

  typedef enum logic [1:0] {IDLE, PRED, WAIT, RESP} state_t;

  state_t           state;
  logic [w_ind-1:0] idx_q;
  logic [w_ind-1:0] lk_idx;
  logic [w_ind-1:0] pht_index;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [w_ind-1:0] mem_idx  [DEPTH];
  logic             mem_pred [DEPTH];
  logic             pred_out_valid;
  logic             pred_out_taken;
  logic             mispredict;
  logic             pht_predict;
  logic             pht_resolve;
  logic             pht_incr;
  logic             pht_decr;
  logic             lk_ready;
  logic             res_ready;
  logic             res_acc;
  logic             lk_acc;
  logic             push;
  logic             push_pred;
  logic             unused_pc;

`ifdef BP_GHR_XOR_EN
  logic [w_ind-1:0] ghr;
  assign lk_idx = bus.lk_pc[w_ind+1:2] ^ ghr;
`else
  assign lk_idx = bus.lk_pc[w_ind+1:2];
`endif

  assign unused_pc = ^{bus.lk_pc[W-1:w_ind+2], bus.lk_pc[1:0]};

  // A pending resolve blocks lookup so the resolve wins the same-cycle arbitration.
  assign res_ready = (state == IDLE) && (cnt != '0);
  assign lk_ready  = (state == IDLE) && (cnt < CW'(DEPTH)) && !(bus.res_valid && (cnt != '0));
  assign res_acc   = bus.res_valid && res_ready;
  assign lk_acc    = bus.lk_valid && lk_ready;

  // A missing PHT answer after the eighth WAIT cycle is recorded as not-taken.
  assign push      = (state == WAIT) && (bus.pht_pred_valid || (tmo_cnt == TMO_LAST));
  assign push_pred = bus.pht_pred_valid & bus.pht_pred;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      idx_q          <= '0;
      pht_index      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      tmo_cnt        <= '0;
      pred_out_valid <= 1'b0;
      pred_out_taken <= 1'b0;
      mispredict     <= 1'b0;
      pht_predict    <= 1'b0;
      pht_resolve    <= 1'b0;
      pht_incr       <= 1'b0;
      pht_decr       <= 1'b0;
`ifdef BP_GHR_XOR_EN
      ghr            <= '0;
`endif
    end else begin
      pred_out_valid <= 1'b0;
      pred_out_taken <= 1'b0;
      mispredict     <= 1'b0;
      pht_predict    <= 1'b0;
      pht_resolve    <= 1'b0;
      pht_incr       <= 1'b0;
      pht_decr       <= 1'b0;
      case (state)
        IDLE: begin
          if (res_acc) begin
            pht_resolve <= 1'b1;
            pht_index   <= mem_idx[rd_ptr];
            pht_incr    <= bus.res_taken;
            pht_decr    <= !bus.res_taken;
            mispredict  <= mem_pred[rd_ptr] != bus.res_taken;
            rd_ptr      <= rd_ptr + PW'(1);
            cnt         <= cnt - CW'(1);
`ifdef BP_GHR_XOR_EN
            ghr         <= {ghr[w_ind-2:0], bus.res_taken};
`endif
          end else if (lk_acc) begin
            idx_q       <= lk_idx;
            pht_index   <= lk_idx;
            pht_predict <= 1'b1;
            state       <= PRED;
          end
        end
        PRED: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (push) begin
            pred_out_valid <= 1'b1;
            pred_out_taken <= push_pred;
            wr_ptr         <= wr_ptr + PW'(1);
            cnt            <= cnt + CW'(1);
            state          <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx[wr_ptr]  <= idx_q;
      mem_pred[wr_ptr] <= push_pred;
    end
  end

  assign bus.lk_ready       = lk_ready;
  assign bus.res_ready      = res_ready;
  assign bus.pred_out_valid = pred_out_valid;
  assign bus.pred_out_taken = pred_out_taken;
  assign bus.mispredict     = mispredict;
  assign bus.pht_predict    = pht_predict;
  assign bus.pht_resolve    = pht_resolve;
  assign bus.pht_incr       = pht_incr;
  assign bus.pht_decr       = pht_decr;
  assign bus.pht_index      = pht_index;
  assign bus.fifo_cnt       = cnt;
endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Self-checking bench for bp_pht_ctrl: scoreboarded predictions plus an in-order model of the in-flight FIFO.
module tb_bp_pht_ctrl;
  localparam int unsigned W  = 32;
  localparam int unsigned WI = 4;
  localparam int unsigned D  = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  bit             exp_q[$];
  logic [WI-1:0]  m_idx[$];
  bit             m_pred[$];
  logic [WI-1:0]  m_ghr = '0;

  bp_pht_ctrl_if #(.W(W), .w_ind(WI), .DEPTH(D)) bus ();
  bp_pht_ctrl #(.W(W), .w_ind(WI), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Strobe exclusivity watched on every cycle.
  always @(negedge clk) begin
    checks++;
    if (bus.pht_predict && bus.pht_resolve) begin
      errors++;
      $display("FAIL strobe_overlap: predict=%0b resolve=%0b required not both 1 at %0t", bus.pht_predict, bus.pht_resolve, $time);
    end
    checks++;
    if (!bus.pht_resolve && (bus.pht_incr || bus.pht_decr)) begin
      errors++;
      $display("FAIL incdec_idle: incr=%0b decr=%0b required 0 without resolve at %0t", bus.pht_incr, bus.pht_decr, $time);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [WI-1:0] exp_index(input logic [W-1:0] pc);
    logic [WI-1:0] r;
    r = pc[WI+1:2];
`ifdef BP_GHR_XOR_EN
    r = r ^ m_ghr;
`endif
    return r;
  endfunction

  task automatic start_lookup(input logic [W-1:0] pc, output bit ok);
    bit got = 0;
    bus.lk_valid = 1'b1;
    bus.lk_pc    = pc;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (bus.lk_ready) got = 1;
      else @(negedge clk);
    end
    ok = got;
    if (!got) begin
      checks++; errors++;
      $display("FAIL lk_ready_wait: lk_ready stayed %0b, required 1", bus.lk_ready);
      bus.lk_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.lk_valid = 1'b0;
    checks++;
    if (bus.pht_predict !== 1'b1) begin
      errors++; $display("FAIL pht_predict: got %0b required 1", bus.pht_predict);
    end
    checks++;
    if (bus.pht_index !== exp_index(pc)) begin
      errors++; $display("FAIL lookup_index: got 0x%0h required 0x%0h", bus.pht_index, exp_index(pc));
    end
  endtask

  task automatic finish_lookup(input int lat, input bit pred);
    bit seen = 0;
    bit exp_t;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.pred_out_valid) begin
        seen = 1;
        bus.pht_pred_valid = 1'b0;
        bus.pht_pred       = 1'b0;
        exp_t = exp_q.pop_front();
        checks++;
        if (bus.pred_out_taken !== exp_t) begin
          errors++; $display("FAIL pred_out_taken: got %0b required %0b", bus.pred_out_taken, exp_t);
        end
        checks++;
        if (k != ((lat == 0) ? 9 : lat + 1)) begin
          errors++; $display("FAIL pred_latency: got %0d required %0d", k, (lat == 0) ? 9 : lat + 1);
        end
        checks++;
        if (int'(bus.fifo_cnt) != m_idx.size()) begin
          errors++; $display("FAIL fifo_cnt_push: got %0d required %0d", bus.fifo_cnt, m_idx.size());
        end
      end else if (lat != 0 && k == lat) begin
        bus.pht_pred_valid = 1'b1;
        bus.pht_pred       = pred;
      end else begin
        bus.pht_pred_valid = 1'b0;
        bus.pht_pred       = 1'b0;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL pred_out_wait: pred_out_valid=0 after 20 cycles, required pulse");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      bus.pht_pred_valid = 1'b0;
    end
  endtask

  task automatic do_lookup(input logic [W-1:0] pc, input bit pred, input int lat);
    bit ok;
    bit ep;
    ep = (lat == 0) ? 1'b0 : pred;
    exp_q.push_back(ep);
    start_lookup(pc, ok);
    if (!ok) begin
      void'(exp_q.pop_back());
      return;
    end
    m_idx.push_back(exp_index(pc));
    m_pred.push_back(ep);
    finish_lookup(lat, pred);
  endtask

  task automatic do_resolve(input bit taken);
    bit got = 0;
    logic [WI-1:0] hi;
    bit hp;
    bus.res_valid = 1'b1;
    bus.res_taken = taken;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (bus.res_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL res_ready_wait: res_ready stayed %0b, required 1", bus.res_ready);
      bus.res_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.res_valid = 1'b0;
    bus.res_taken = 1'b0;
    hi = m_idx.pop_front();
    hp = m_pred.pop_front();
`ifdef BP_GHR_XOR_EN
    m_ghr = {m_ghr[WI-2:0], taken};
`endif
    checks++;
    if (bus.pht_resolve !== 1'b1) begin
      errors++; $display("FAIL pht_resolve: got %0b required 1", bus.pht_resolve);
    end
    checks++;
    if (bus.pht_index !== hi) begin
      errors++; $display("FAIL resolve_index: got 0x%0h required 0x%0h", bus.pht_index, hi);
    end
    checks++;
    if (bus.pht_incr !== taken || bus.pht_decr !== !taken) begin
      errors++; $display("FAIL incr_decr: got incr=%0b decr=%0b required incr=%0b decr=%0b", bus.pht_incr, bus.pht_decr, taken, !taken);
    end
    checks++;
    if (bus.mispredict !== (hp != taken)) begin
      errors++; $display("FAIL mispredict: got %0b required %0b", bus.mispredict, hp != taken);
    end
    checks++;
    if (int'(bus.fifo_cnt) != m_idx.size()) begin
      errors++; $display("FAIL fifo_cnt_pop: got %0d required %0d", bus.fifo_cnt, m_idx.size());
    end
`ifdef BP_GHR_XOR_EN
    checks++;
    if (dut.ghr !== m_ghr) begin
      errors++; $display("FAIL ghr: got 0x%0h required 0x%0h", dut.ghr, m_ghr);
    end
`endif
  endtask

  task automatic test_reset();
    bit ok;
    bit stale = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.fifo_cnt !== '0 || bus.pred_out_valid !== 1'b0 || bus.pht_predict !== 1'b0 || bus.mispredict !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: fifo_cnt=%0d pred_out_valid=%0b pht_predict=%0b mispredict=%0b required all 0", bus.fifo_cnt, bus.pred_out_valid, bus.pht_predict, bus.mispredict);
    end
    checks++;
    if (bus.lk_ready !== 1'b1) begin
      errors++; $display("FAIL reset_lk_ready: got %0b required 1", bus.lk_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    start_lookup(W'(32'h30), ok);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (bus.fifo_cnt !== '0 || bus.pht_predict !== 1'b0 || bus.pht_resolve !== 1'b0 || bus.pred_out_valid !== 1'b0) begin
      errors++; $display("FAIL midwait_reset: fifo_cnt=%0d predict=%0b resolve=%0b pred_out_valid=%0b required all 0", bus.fifo_cnt, bus.pht_predict, bus.pht_resolve, bus.pred_out_valid);
    end
    #1;
    checks++;
    if (bus.lk_ready !== 1'b1) begin
      errors++; $display("FAIL midwait_lk_ready: got %0b required 1", bus.lk_ready);
    end
    bus.pht_pred_valid = 1'b1;
    bus.pht_pred       = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.pred_out_valid) stale = 1;
    end
    bus.pht_pred_valid = 1'b0;
    bus.pht_pred       = 1'b0;
    checks++;
    if (stale) begin
      errors++; $display("FAIL discarded_lookup: pred_out_valid seen 1, required 0 after reset");
    end
  endtask

  task automatic test_lookup_resolve();
    do_lookup(W'(32'h30), 1'b1, 2);
    do_resolve(1'b0);
  endtask

  task automatic test_full();
    do_lookup(W'(32'h100), 1'b1, 1);
    do_lookup(W'(32'h104), 1'b0, 3);
    do_lookup(W'(32'h208), 1'b1, 2);
    do_lookup(W'(32'h30c), 1'b1, 8);
    @(negedge clk);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = W'(32'h400);
    #1;
    checks++;
    if (bus.lk_ready !== 1'b0 || bus.fifo_cnt !== 3'd4) begin
      errors++; $display("FAIL full_stall: lk_ready=%0b fifo_cnt=%0d required 0 and 4", bus.lk_ready, bus.fifo_cnt);
    end
    bus.lk_valid = 1'b0;
    do_resolve(1'b1);
    #1;
    checks++;
    if (bus.lk_ready !== 1'b1) begin
      errors++; $display("FAIL full_release: lk_ready=%0b required 1", bus.lk_ready);
    end
    do_resolve(1'b0);
    do_resolve(1'b1);
    do_resolve(1'b0);
  endtask

  task automatic test_collide();
    logic [WI-1:0] hi;
    bit hp;
    do_lookup(W'(32'h44), 1'b1, 1);
    @(negedge clk);
    bus.res_valid = 1'b1;
    bus.res_taken = 1'b1;
    bus.lk_valid  = 1'b1;
    bus.lk_pc     = W'(32'h58);
    #1;
    checks++;
    if (bus.res_ready !== 1'b1 || bus.lk_ready !== 1'b0) begin
      errors++; $display("FAIL collide_arb: res_ready=%0b lk_ready=%0b required 1 and 0", bus.res_ready, bus.lk_ready);
    end
    @(negedge clk);
    bus.res_valid = 1'b0;
    hi = m_idx.pop_front();
    hp = m_pred.pop_front();
`ifdef BP_GHR_XOR_EN
    m_ghr = {m_ghr[WI-2:0], 1'b1};
`endif
    checks++;
    if (bus.pht_resolve !== 1'b1 || bus.pht_index !== hi || bus.mispredict !== (hp != 1'b1) || bus.fifo_cnt !== '0) begin
      errors++; $display("FAIL collide_resolve: resolve=%0b index=0x%0h mispredict=%0b fifo_cnt=%0d required 1 0x%0h %0b 0", bus.pht_resolve, bus.pht_index, bus.mispredict, bus.fifo_cnt, hi, hp != 1'b1);
    end
    #1;
    checks++;
    if (bus.lk_ready !== 1'b1) begin
      errors++; $display("FAIL collide_lk_ready: got %0b required 1", bus.lk_ready);
    end
    @(negedge clk);
    bus.lk_valid = 1'b0;
    checks++;
    if (bus.pht_predict !== 1'b1 || bus.pht_index !== exp_index(W'(32'h58))) begin
      errors++; $display("FAIL collide_lookup: predict=%0b index=0x%0h required 1 0x%0h", bus.pht_predict, bus.pht_index, exp_index(W'(32'h58)));
    end
    exp_q.push_back(1'b0);
    m_idx.push_back(exp_index(W'(32'h58)));
    m_pred.push_back(1'b0);
    finish_lookup(2, 1'b0);
    do_resolve(1'b1);
  endtask

  task automatic test_timeout();
    do_lookup(W'(32'h1c), 1'b1, 0);
    do_resolve(1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      if (m_idx.size() == D || (m_idx.size() > 0 && $urandom_range(0, 1) == 1))
        do_resolve(1'($urandom_range(0, 1)));
      else
        do_lookup(W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 8)));
    end
    while (m_idx.size() > 0) do_resolve(1'($urandom_range(0, 1)));
    #1;
    checks++;
    if (bus.fifo_cnt !== '0 || exp_q.size() != 0) begin
      errors++; $display("FAIL drain: fifo_cnt=%0d pending=%0d required 0 and 0", bus.fifo_cnt, exp_q.size());
    end
  endtask

  initial begin
    rst                = 1'b0;
    bus.lk_valid       = 1'b0;
    bus.lk_pc          = '0;
    bus.res_valid      = 1'b0;
    bus.res_taken      = 1'b0;
    bus.pht_pred       = 1'b0;
    bus.pht_pred_valid = 1'b0;
    test_reset();
    test_lookup_resolve();
    test_full();
    test_collide();
    test_timeout();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bp_pht_ctrl.md
BP_PHT_CTRL -- requirements
Module: bp_pht_ctrl

Interface
REQ-001 Parameters: W, default 32, PC width; w_ind, default 4, PHT index width; DEPTH, default 4, in-flight FIFO entries (power of 2).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous reset, active-low.
REQ-004 lk_valid  in  1  fetch lookup request; lk_pc  in  W  branch PC.
REQ-005 lk_ready  out  1  lookup accepted when lk_valid && lk_ready at a clk edge.
REQ-006 pred_out_valid  out  1  one-cycle pulse; pred_out_taken  out  1  prediction returned to fetch.
REQ-007 res_valid  in  1  execute resolution; res_taken  in  1  actual outcome; res_ready  out  1  resolution accepted when both high.
REQ-008 mispredict  out  1  one-cycle pulse, stored prediction != res_taken.
REQ-009 pht_predict, pht_resolve, pht_incr, pht_decr  out  1 each  PHT command strobes.
REQ-010 pht_index  out  w_ind  PHT index; pht_pred  in  1  PHT FINAL_PRED; pht_pred_valid  in  1  PHT pred_valid.
REQ-011 fifo_cnt  out  log2(DEPTH)+1  in-flight entry count.

Function
REQ-012 FSM states IDLE, PRED, WAIT, RESP; all command strobes registered.
REQ-013 Index idx = lk_pc[w_ind+1:2] XOR ghr (see REQ-026); ghr is a w_ind-bit global history register.
REQ-014 lk_ready = (state==IDLE) && (fifo_cnt<DEPTH) && !(res_valid && fifo_cnt>0).
REQ-015 res_ready = (state==IDLE) && (fifo_cnt>0); resolution has priority over lookup in the same cycle.
REQ-016 Lookup accept in IDLE: latch idx, go to PRED; in PRED drive pht_predict=1, pht_index=idx for exactly one cycle, go to WAIT.
REQ-017 WAIT: on pht_pred_valid capture pht_pred, push {idx,pht_pred} into FIFO, go to RESP; RESP drives pred_out_valid=1, pred_out_taken=captured value for one cycle, then returns to IDLE.
REQ-018 WAIT timeout: if pht_pred_valid is absent for 8 consecutive WAIT cycles, push {idx,0}, go to RESP with pred_out_taken=0.
REQ-019 Resolve accept in IDLE: next cycle drive pht_resolve=1, pht_index=FIFO head index, pht_incr=res_taken, pht_decr=!res_taken, pop FIFO, mispredict=(head prediction != res_taken); state remains IDLE; lk_ready=0 in that cycle.
REQ-020 On each resolve, ghr <= {ghr[w_ind-2:0], res_taken}; ghr is not updated speculatively at lookup.
REQ-021 pht_predict and pht_resolve are never high in the same cycle; pht_incr/pht_decr are 0 whenever pht_resolve=0.
REQ-022 Push (RESP entry) and pop (IDLE resolve) are mutually exclusive by construction; fifo_cnt changes by at most 1 per cycle.
REQ-023 FIFO full (fifo_cnt==DEPTH): lookups stalled, resolves still accepted; empty: res_ready=0, res_valid ignored, no mispredict.
REQ-024 FIFO pointers wrap modulo DEPTH; order strictly in-order (oldest prediction resolved first).

Reset
REQ-025 rst==0 at a clk edge: state=IDLE, FIFO empty (fifo_cnt=0, pointers 0), ghr=0, all outputs 0 except lk_ready, which is 1 after the reset cycle; in-progress lookup or resolve is discarded without PHT strobe.

Configuration
REQ-026 Macro BP_GHR_XOR_EN: defined -> gshare index per REQ-013; undefined -> bimodal idx = lk_pc[w_ind+1:2], ghr register and its update removed, all other behaviour identical.

Verification
REQ-027 Reset: rst=0 one edge mid-WAIT -> next cycle state IDLE, fifo_cnt=0, all strobes 0, lk_ready=1.
REQ-028 Lookup lk_pc=0x30, ghr=0, PHT returns pht_pred=1 two cycles after pht_predict -> pht_index=0xC, pred_out_valid pulse with pred_out_taken=1, fifo_cnt=1.
REQ-029 Resolve res_taken=0 with head pred=1, index 0xC -> pht_resolve=1, pht_decr=1, pht_incr=0, pht_index=0xC, mispredict=1, fifo_cnt=0, ghr=0x0 (BP_GHR_XOR_EN).
REQ-030 Four lookups, no resolve (DEPTH=4) -> fifo_cnt=4, lk_ready=0; one resolve -> fifo_cnt=3, lk_ready=1 next IDLE cycle.
REQ-031 res_valid and lk_valid together in IDLE, fifo_cnt=1 -> resolve taken first, lookup accepted the following cycle; no cycle with pht_predict && pht_resolve.
REQ-032 pht_pred_valid held low 8 WAIT cycles -> pred_out_taken=0 pulse, FIFO entry pred=0; later res_taken=1 -> mispredict=1, pht_incr=1.
